// File: rtl/key_input_reader.sv
// Pushbutton reader peripheral on an 8-bit active-low-strobe slave bus.
// Synchronises and debounces WIDTH active-low keys, latches press events
// into a write-1-to-clear edge register and raises a maskable interrupt.
//
// Ports:
//   iClk           system clock, rising edge
//   iReset_n       asynchronous active-low reset
//   iChip_select_n slave select, active-low
//   iRead_n        read strobe, active-low
//   iWrite_n       write strobe, active-low
//   iAddress       register select: 0 state, 1 edge, 2 mask, 3 zero
//   iWrite_Data    write data
//   oRead_Data     registered read data, one cycle latency
//   oIrq           registered interrupt, OR of edge & mask
//   iKey_n         raw pushbuttons, active-low, asynchronous
module key_input_reader #(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic             iClk,
   input  logic             iReset_n,
   input  logic             iChip_select_n,
   input  logic             iRead_n,
   input  logic             iWrite_n,
   input  logic [1:0]       iAddress,
   input  logic [7:0]       iWrite_Data,
   output logic [7:0]       oRead_Data,
   output logic             oIrq,
   input  logic [WIDTH-1:0] iKey_n
);

   localparam logic [CNT_W-1:0] CNT_TERM  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0]       ADDR_KEYS = 2'd0;
   localparam logic [1:0]       ADDR_EDGE = 2'd1;
   localparam logic [1:0]       ADDR_MASK = 2'd2;

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0] last_key_q, last_key_d;
   logic [WIDTH-1:0] deb_q, deb_d;
   logic [WIDTH-1:0] edge_q, edge_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       rdata_q, rdata_d;
   logic             irq_q, irq_d;

   logic [WIDTH-1:0] sync_key;
   logic [WIDTH-1:0] clr;
   logic             rd_en, wr_en;
   logic             unused_wdata;

   // Upper write-data bits beyond WIDTH have no destination.
   assign unused_wdata = ^iWrite_Data;

   // Two-flop synchroniser; reset value is "released".
   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= iKey_n;
         sync2_q <= sync1_q;
      end
   end

   assign sync_key = ~sync2_q;

   // Shared debounce counter: any change on any bit restarts the count,
   // terminal count holds and keeps loading the stable value.
   always_comb begin
      last_key_d = last_key_q;
      cnt_d      = cnt_q;
      deb_d      = deb_q;
      if (sync_key != last_key_q) begin
         last_key_d = sync_key;
         cnt_d      = '0;
      end else if (cnt_q == CNT_TERM) begin
         deb_d = last_key_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Bus decode, edge capture (set beats clear), mask, irq and read mux.
   always_comb begin
      rd_en   = !iChip_select_n && !iRead_n;
      wr_en   = !iChip_select_n && !iWrite_n;
      clr     = '0;
      mask_d  = mask_q;
      rdata_d = rdata_q;
      if (wr_en && (iAddress == ADDR_EDGE)) clr    = iWrite_Data[WIDTH-1:0];
      if (wr_en && (iAddress == ADDR_MASK)) mask_d = iWrite_Data[WIDTH-1:0];
      edge_d = (edge_q & ~clr) | (deb_d & ~deb_q);
      irq_d  = |(edge_q & mask_q);
      if (rd_en) begin
         case (iAddress)
            ADDR_KEYS: rdata_d = 8'(deb_q);
            ADDR_EDGE: rdata_d = 8'(edge_q);
            ADDR_MASK: rdata_d = 8'(mask_q);
            default:   rdata_d = 8'h00;
         endcase
      end
   end

   // State registers.
   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         last_key_q <= '0;
         cnt_q      <= '0;
         deb_q      <= '0;
         edge_q     <= '0;
         mask_q     <= '0;
         rdata_q    <= 8'h00;
         irq_q      <= 1'b0;
      end else begin
         last_key_q <= last_key_d;
         cnt_q      <= cnt_d;
         deb_q      <= deb_d;
         edge_q     <= edge_d;
         mask_q     <= mask_d;
         rdata_q    <= rdata_d;
         irq_q      <= irq_d;
      end
   end

   assign oRead_Data = rdata_q;
   assign oIrq       = irq_q;

endmodule

// File: tb/tb_key_input_reader.sv
// Self-checking bench for key_input_reader with WIDTH=4, DEBOUNCE_CYCLES=4.
module tb_key_input_reader;

   localparam int unsigned W  = 4;
   localparam int unsigned DC = 4;

   logic         iClk = 1'b0;
   logic         iReset_n;
   logic         iChip_select_n;
   logic         iRead_n;
   logic         iWrite_n;
   logic [1:0]   iAddress;
   logic [7:0]   iWrite_Data;
   logic [7:0]   oRead_Data;
   logic         oIrq;
   logic [W-1:0] iKey_n;

   int n_vec = 0;
   int n_err = 0;

   key_input_reader #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
      .iClk(iClk), .iReset_n(iReset_n), .iChip_select_n(iChip_select_n),
      .iRead_n(iRead_n), .iWrite_n(iWrite_n), .iAddress(iAddress),
      .iWrite_Data(iWrite_Data), .oRead_Data(oRead_Data), .oIrq(oIrq),
      .iKey_n(iKey_n)
   );

   always #5 iClk = ~iClk;

   // Reference model: the debounced value changes once the last DC+1
   // synchronised samples (two cycles old) all agree.
   logic [W-1:0] pipe_m [0:DC+1];
   logic [W-1:0] deb_m, edge_m, mask_m;
   logic [7:0]   rd_m;
   logic         irq_m;

   always @(posedge iClk or negedge iReset_n) begin : model
      logic [W-1:0] nd, clr;
      logic         stable;
      if (!iReset_n) begin
         for (int i = 0; i <= DC + 1; i++) pipe_m[i] <= '0;
         deb_m <= '0; edge_m <= '0; mask_m <= '0; rd_m <= 8'h00; irq_m <= 1'b0;
      end else begin
         stable = 1'b1;
         for (int j = 2; j <= DC + 1; j++)
            if (pipe_m[j] != pipe_m[1]) stable = 1'b0;
         nd  = stable ? pipe_m[1] : deb_m;
         clr = (!iChip_select_n && !iWrite_n && iAddress == 2'd1) ? iWrite_Data[W-1:0] : '0;
         if (!iChip_select_n && !iRead_n)
            rd_m <= (iAddress == 2'd0) ? {4'h0, deb_m} :
                    (iAddress == 2'd1) ? {4'h0, edge_m} :
                    (iAddress == 2'd2) ? {4'h0, mask_m} : 8'h00;
         if (!iChip_select_n && !iWrite_n && iAddress == 2'd2) mask_m <= iWrite_Data[W-1:0];
         edge_m <= (edge_m & ~clr) | (nd & ~deb_m);
         irq_m  <= |(edge_m & mask_m);
         deb_m  <= nd;
         pipe_m[0] <= ~iKey_n;
         for (int j = 1; j <= DC + 1; j++) pipe_m[j] <= pipe_m[j-1];
      end
   end

   task automatic bus_idle();
      iChip_select_n = 1'b1; iRead_n = 1'b1; iWrite_n = 1'b1;
      iAddress = 2'd0; iWrite_Data = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge iClk);
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
      iChip_select_n = 1'b0; iRead_n = 1'b0; iWrite_n = 1'b1; iAddress = a;
      @(negedge iClk);
      d = oRead_Data;
      bus_idle();
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
      iChip_select_n = 1'b0; iRead_n = 1'b1; iWrite_n = 1'b0;
      iAddress = a; iWrite_Data = d;
      @(negedge iClk);
      bus_idle();
   endtask

   task automatic test_reset();
      logic [7:0] d;
      iReset_n = 1'b0; iKey_n = '0; bus_idle();
      idle(3);
      iReset_n = 1'b1;
      n_vec++; if (oIrq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %0b want 0", oIrq); end
      n_vec++; if (oRead_Data !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h want 00", oRead_Data); end
      idle(2);
      iKey_n = '1;
      for (int a = 0; a < 3; a++) begin
         bus_rd(2'(a), d);
         n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL reset_reg%0d: got %h want 00", a, d); end
      end
      idle(10);
      bus_rd(2'd1, d);
      n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL reset_no_edge: got %h want 00", d); end
   endtask

   task automatic test_clean_press();
      logic [7:0] d, first_val;
      int first;
      logic irq_seen;
      first = -1; first_val = 8'h00; irq_seen = 1'b0;
      iKey_n = 4'b1011;
      iChip_select_n = 1'b0; iRead_n = 1'b0; iAddress = 2'd0;
      for (int k = 0; k < 12; k++) begin
         @(negedge iClk);
         if (oIrq) irq_seen = 1'b1;
         if (first < 0 && oRead_Data != 8'h00) begin first = k; first_val = oRead_Data; end
      end
      bus_idle();
      n_vec++; if (first !== 7) begin n_err++; $display("FAIL press_latency: got %0d want 7", first); end
      n_vec++; if (first_val !== 8'h04) begin n_err++; $display("FAIL press_state: got %h want 04", first_val); end
      bus_rd(2'd1, d);
      n_vec++; if (d !== 8'h04) begin n_err++; $display("FAIL press_edge: got %h want 04", d); end
      bus_rd(2'd1, d);
      n_vec++; if (d !== 8'h04) begin n_err++; $display("FAIL read_no_clear: got %h want 04", d); end
      iKey_n = 4'b1111;
      idle(12);
      if (oIrq) irq_seen = 1'b1;
      n_vec++; if (irq_seen !== 1'b0) begin n_err++; $display("FAIL press_irq_masked: got 1 want 0"); end
      bus_rd(2'd1, d);
      n_vec++; if (d !== 8'h04) begin n_err++; $display("FAIL release_no_edge: got %h want 04", d); end
      bus_rd(2'd0, d);
      n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL release_state: got %h want 00", d); end
      bus_wr(2'd1, 8'hFF);
   endtask

   task automatic test_bounce();
      logic [7:0] d;
      int rises, first;
      logic prev;
      rises = 0; first = -1; prev = 1'b0;
      iChip_select_n = 1'b0; iRead_n = 1'b0; iAddress = 2'd0;
      for (int t = 0; t < 40; t++) begin
         if (t % 2 == 0 && t <= 20) iKey_n[0] = ~iKey_n[0];
         @(negedge iClk);
         if (oRead_Data[0] && !prev) begin rises++; if (first < 0) first = t; end
         prev = oRead_Data[0];
      end
      bus_idle();
      n_vec++; if (rises !== 1) begin n_err++; $display("FAIL bounce_rises: got %0d want 1", rises); end
      n_vec++; if (first !== 27) begin n_err++; $display("FAIL bounce_latency: got %0d want 27", first); end
      bus_rd(2'd1, d);
      n_vec++; if (d !== 8'h01) begin n_err++; $display("FAIL bounce_edge: got %h want 01", d); end
      iKey_n = 4'b1111;
      idle(12);
      bus_wr(2'd1, 8'hFF);
   endtask

   task automatic test_irq_flow();
      logic [7:0] d;
      int fe, fi;
      fe = -1; fi = -1;
      bus_wr(2'd2, 8'h0F);
      bus_rd(2'd2, d);
      n_vec++; if (d !== 8'h0F) begin n_err++; $display("FAIL mask_rd: got %h want 0F", d); end
      iKey_n = 4'b1101;
      iChip_select_n = 1'b0; iRead_n = 1'b0; iAddress = 2'd1;
      for (int k = 0; k < 12; k++) begin
         @(negedge iClk);
         if (fe < 0 && oRead_Data[1]) fe = k;
         if (fi < 0 && oIrq) fi = k;
      end
      bus_idle();
      n_vec++; if (fe !== 7) begin n_err++; $display("FAIL irq_edge_time: got %0d want 7", fe); end
      n_vec++; if (fi !== 7) begin n_err++; $display("FAIL irq_rise_time: got %0d want 7", fi); end
      bus_wr(2'd1, 8'h02);
      n_vec++; if (oIrq !== 1'b1) begin n_err++; $display("FAIL irq_hold: got %0b want 1", oIrq); end
      @(negedge iClk);
      n_vec++; if (oIrq !== 1'b0) begin n_err++; $display("FAIL irq_fall: got %0b want 0", oIrq); end
      bus_rd(2'd1, d);
      n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL irq_clr_edge: got %h want 00", d); end
      iKey_n = 4'b1111;
      idle(12);
   endtask

   task automatic test_collision();
      logic [7:0] d;
      iKey_n = 4'b0111;
      idle(6);
      bus_wr(2'd1, 8'h08);
      bus_rd(2'd1, d);
      n_vec++; if (d !== 8'h08) begin n_err++; $display("FAIL collide_set_wins: got %h want 08", d); end
      n_vec++; if (oIrq !== 1'b1) begin n_err++; $display("FAIL collide_irq: got %0b want 1", oIrq); end
      iKey_n = 4'b1111;
      idle(12);
      bus_wr(2'd1, 8'hFF);
   endtask

   task automatic test_async_reset();
      logic [7:0] d;
      iKey_n = 4'b1010;
      idle(10);
      bus_rd(2'd1, d);
      n_vec++; if (d !== 8'h05) begin n_err++; $display("FAIL areset_pre_edge: got %h want 05", d); end
      @(negedge iClk);
      n_vec++; if (oIrq !== 1'b1) begin n_err++; $display("FAIL areset_pre_irq: got %0b want 1", oIrq); end
      #2 iReset_n = 1'b0;
      #1;
      n_vec++; if (oIrq !== 1'b0) begin n_err++; $display("FAIL areset_irq: got %0b want 0", oIrq); end
      n_vec++; if (oRead_Data !== 8'h00) begin n_err++; $display("FAIL areset_rdata: got %h want 00", oRead_Data); end
      iKey_n = 4'b1111;
      @(negedge iClk);
      iReset_n = 1'b1;
      for (int a = 0; a < 3; a++) begin
         bus_rd(2'(a), d);
         n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL areset_reg%0d: got %h want 00", a, d); end
      end
   endtask

   task automatic test_random();
      int hold;
      hold = 0;
      for (int c = 0; c < 600; c++) begin
         n_vec++;
         if (oIrq !== irq_m) begin n_err++; $display("FAIL rand_irq c%0d: got %0b want %0b", c, oIrq, irq_m); end
         n_vec++;
         if (oRead_Data !== rd_m) begin n_err++; $display("FAIL rand_rdata c%0d: got %h want %h", c, oRead_Data, rd_m); end
         if (hold == 0) begin
            iKey_n = W'($urandom);
            hold = $urandom_range(1, 9);
         end
         hold--;
         iChip_select_n = ($urandom_range(0, 3) == 0);
         iRead_n        = ($urandom_range(0, 1) == 0);
         iWrite_n       = ($urandom_range(0, 3) != 0);
         iAddress       = 2'($urandom);
         iWrite_Data    = 8'($urandom);
         @(negedge iClk);
      end
      bus_idle();
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_irq_flow();
      test_collision();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/key_input_reader.md
Name: key_input_reader

Overview:
- Avalon-MM slave peripheral: the read-side counterpart of the HEX write-only display controller.
- Samples active-low pushbuttons, synchronises and debounces them, latches press events and raises a maskable interrupt.
- The Nios II reads button state and event flags over the same 8-bit slave bus style: chip-select and read/write strobes, all active-low.

Parameters:
- WIDTH, 4, number of key inputs (1..8).
- DEBOUNCE_CYCLES, 500000, stable cycles required before the debounced state updates (10 ms at 50 MHz); must be >= 2.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- iClk, in, 1, system clock; all logic is on its rising edge.
- iReset_n, in, 1, reset: asynchronous assert, active-low.
- iChip_select_n, in, 1, slave select, active-low.
- iRead_n, in, 1, read strobe, active-low.
- iWrite_n, in, 1, write strobe, active-low.
- iAddress, in, 2, register select.
- iWrite_Data, in, 8, write data (bus width is a multiple of 8).
- oRead_Data, out, 8, registered read data.
- oIrq, out, 1, interrupt request, active-high.
- iKey_n, in, WIDTH, raw pushbuttons, active-low, asynchronous to iClk.

Behaviour:
- Reset (iReset_n=0, takes effect immediately regardless of clock):
  - sync stages = all 1s (released).
  - debounce counter = 0; debounced state = 0.
  - edge capture = 0; irq mask = 0.
  - oRead_Data = 8'h00; oIrq = 0.
- Reset mid-debounce or mid-read discards all in-progress state; no event is generated on reset release.
- Synchroniser: two-flop chain per bit on iKey_n, then inverted, so pressed = 1. The result is sync_key.
- Debounce: one shared counter, tracked against a register last_key.
  - If sync_key != last_key: last_key <= sync_key and counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: debounced <= last_key; counter holds.
  - Else: counter increments.
  - The counter never wraps.
  - Minimum latency from an iKey_n edge to the debounced update is 2 + 1 + DEBOUNCE_CYCLES cycles (2 sync, 1 to load last_key, DEBOUNCE_CYCLES to reach terminal count).
  - Any bounce restarts the count for all bits.
- Edge capture: bit i sets when debounced[i] goes 0->1 (press only; release sets nothing).
  - Clear is write-1-to-clear.
  - If a set and a clear hit the same bit in the same cycle, set wins.
- Register map (unused upper bits read 0, writes to them ignored):
  - addr 0: debounced state, read-only; writes ignored.
  - addr 1: edge capture, read; write 1 clears the bit.
  - addr 2: irq mask, read/write.
  - addr 3: reads 8'h00; writes ignored.
- Reads: when iChip_select_n=0 and iRead_n=0 at a clock edge, oRead_Data <= selected register.
  - Read latency is fixed at 1 cycle; no wait states.
  - oRead_Data holds its value until the next read and is not cleared on deselect.
  - Reading has no side effects; in particular, reading the edge register does not clear it.
- Writes: take effect at the clock edge where iChip_select_n=0 and iWrite_n=0.
- Read and write asserted together: both are performed. oRead_Data returns the pre-write value.
- Strobes with iChip_select_n=1 are ignored entirely.
- oIrq = OR of (edge capture & mask), driven from a register.
  - Asserts 1 cycle after the edge bit sets, provided the mask bit is set.
  - Deasserts 1 cycle after the clearing write or the mask write.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=4):
- Reset: hold iReset_n=0 with iKey_n=4'b0000, then release.
  - Reads of addr 0/1/2 return 8'h00 and oIrq=0; no edge is captured at release.
- Clean press: iKey_n[2] 1->0 and held.
  - Addr 0 reads 8'h04 no earlier than 7 cycles after the edge.
  - Addr 1 reads 8'h04.
  - oIrq stays 0 while mask = 0.
- Bounce: toggle iKey_n[0] every 2 cycles for 20 cycles, then hold low.
  - Debounced bit 0 rises exactly once, 7 cycles after the final toggle.
  - Edge register = 8'h01.
- IRQ flow: write addr 2 = 8'h0F, then press key 1.
  - oIrq rises 1 cycle after edge bit 1 sets.
  - Write addr 1 = 8'h02: oIrq falls the next cycle and addr 1 reads 8'h00.
- Set/clear collision: write addr 1 = 8'h08 in the same cycle key 3's debounced bit rises.
  - Addr 1 reads 8'h08 (set wins).
- Async reset mid-operation: with edge = 8'h05 and mask = 8'h0F, pulse iReset_n low between clock edges.
  - oIrq and all registers are 0 immediately, without waiting for a clock edge.
